// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM external bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned SelW  = 4;

  localparam logic RstEnable   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic WriteEnable = 1'b1;

  localparam logic [SelW-1:0] SelFull = {SelW{1'b1}};

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StBusyDm = 2'b01,
    StBusyIf = 2'b10
  } state_e;

  typedef enum logic {
    GntDm = 1'b0,
    GntIf = 1'b1
  } gnt_e;

  function automatic state_e busy_state(gnt_e gnt);
    return (gnt == GntDm) ? StBusyDm : StBusyIf;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Request/acknowledge memory bus between the arbiter (master) and the SoC fabric (slave).
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic             req;
  logic             we;
  logic [SelW-1:0]  sel;
  logic [AddrW-1:0] addr;
  logic [DataW-1:0] wdata;
  logic [DataW-1:0] rdata;
  logic             ack;
  logic             err;

  modport master (
    output req, we, sel, addr, wdata, err,
    input  rdata, ack
  );

  modport slave (
    input  req, we, sel, addr, wdata, err,
    output rdata, ack
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises IF and MEM-stage accesses onto one req/ack bus and stalls the pipeline meanwhile.
// Optional bus-wait abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             if_ce_i,
  input  logic [AddrW-1:0] if_addr_i,
  output logic [DataW-1:0] if_data_o,

  input  logic             dm_ce_i,
  input  logic             dm_we_i,
  input  logic [SelW-1:0]  dm_sel_i,
  input  logic [AddrW-1:0] dm_addr_i,
  input  logic [DataW-1:0] dm_data_i,
  output logic [DataW-1:0] dm_data_o,

  input  logic             flush_i,
  output logic             stallreq_o,

  mem_bus_arbiter_if.master bus
);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [SelW-1:0]  sel_q, sel_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [DataW-1:0] if_data_q, if_data_d;
  logic [DataW-1:0] dm_data_q, dm_data_d;
  logic             if_served_q, if_served_d;
  logic             dm_served_q, dm_served_d;
  logic             drop_q, drop_d;

  logic dm_pend, if_pend, kill, done, abort;
  gnt_e gnt;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntLog = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW   = (CntLog > 8) ? CntLog : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign dm_pend    = (dm_ce_i == ChipEnable) & ~dm_served_q;
  assign if_pend    = (if_ce_i == ChipEnable) & ~if_served_q;
  assign stallreq_o = dm_pend | if_pend;
  // A flush in the ack cycle itself must also suppress the update.
  assign kill       = drop_q | flush_i;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    dm_data_d   = dm_data_q;
    if_served_d = if_served_q;
    dm_served_d = dm_served_q;
    drop_d      = drop_q;
    gnt         = GntDm;
    done        = 1'b0;
    abort       = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (dm_pend || if_pend) begin
          // Data port first: it belongs to the older instruction.
          gnt     = dm_pend ? GntDm : GntIf;
          state_d = busy_state(gnt);
          req_d   = 1'b1;
          if (gnt == GntDm) begin
            we_d    = dm_we_i;
            sel_d   = dm_sel_i;
            addr_d  = dm_addr_i;
            wdata_d = dm_data_i;
          end else begin
            we_d    = ~WriteEnable;
            sel_d   = SelFull;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      StBusyDm, StBusyIf: begin
        if (bus.ack) begin
          done = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          done  = 1'b1;
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end

        if (done) begin
          state_d = StIdle;
          req_d   = 1'b0;
          drop_d  = 1'b0;
          if (!kill) begin
            if (state_q == StBusyDm) begin
              dm_served_d = 1'b1;
              if (abort) begin
                dm_data_d = '0;
              end else if (we_q != WriteEnable) begin
                dm_data_d = bus.rdata;
              end
            end else begin
              if_served_d = 1'b1;
              if_data_d   = abort ? '0 : bus.rdata;
            end
          end
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        err_d = abort;
`endif
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase

    // Pipeline advances (or is flushed): the next instruction needs fresh accesses.
    if (!stallreq_o || flush_i) begin
      if_served_d = 1'b0;
      dm_served_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_data_q   <= '0;
      dm_data_q   <= '0;
      if_served_q <= 1'b0;
      dm_served_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_data_q   <= if_data_d;
      dm_data_q   <= dm_data_d;
      if_served_q <= if_served_d;
      dm_served_q <= dm_served_d;
      drop_q      <= drop_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.req    = req_q;
  assign bus.we     = we_q;
  assign bus.sel    = sel_q;
  assign bus.addr   = addr_q;
  assign bus.wdata  = wdata_q;
  assign if_data_o  = if_data_q;
  assign dm_data_o  = dm_data_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: expected bus transactions queued by stimulus, checked by a bus-side monitor.
module tb_mem_bus_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        dm_ce;
  logic        dm_we;
  logic [3:0]  dm_sel;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_data;
  logic        flush;
  logic        stallreq;

  int n_tests = 0;
  int n_fail  = 0;
  txn_t exp_q[$];

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_ce_i    (if_ce),
    .if_addr_i  (if_addr),
    .if_data_o  (if_data),
    .dm_ce_i    (dm_ce),
    .dm_we_i    (dm_we),
    .dm_sel_i   (dm_sel),
    .dm_addr_i  (dm_addr),
    .dm_data_i  (dm_wdata),
    .dm_data_o  (dm_data),
    .flush_i    (flush),
    .stallreq_o (stallreq),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d);
    txn_t t;
    t.addr = a; t.we = w; t.sel = s; t.wdata = d;
    exp_q.push_back(t);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bus-side monitor: every acknowledged request must match the next queued expectation.
  always @(negedge clk) begin
    if (rst && bus_if.req && bus_if.ack) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_txn", bus_if.addr, 32'hFFFF_FFFF);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        chk("sb_addr", bus_if.addr, t.addr);
        chk("sb_we", {31'd0, bus_if.we}, {31'd0, t.we});
        chk("sb_sel", {28'd0, bus_if.sel}, {28'd0, t.sel});
        if (t.we) chk("sb_wdata", bus_if.wdata, t.wdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; if_ce = 0; if_addr = 0; dm_ce = 0; dm_we = 0; dm_sel = 0;
    dm_addr = 0; dm_wdata = 0; flush = 0;
    bus_if.ack = 1'b0; bus_if.rdata = '0;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_req", bus_if.req, 0);
    chk("rst_we", bus_if.we, 0);
    chk("rst_sel", bus_if.sel, 0);
    chk("rst_addr", bus_if.addr, 0);
    chk("rst_wdata", bus_if.wdata, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_dm_data", dm_data, 0);
    chk("rst_err", bus_if.err, 0);
    chk("rst_stall", stallreq, 0);
    rst = 1'b1;
    cyc();

    // T1: IF read, two BUSY cycles
    cyc(); if_ce = 1; if_addr = 32'h100; push(32'h100, 0, 4'hF, 0);
    #1 chk("t1_c0_stall", stallreq, 1); chk("t1_c0_req", bus_if.req, 0);
    cyc(); #1 chk("t1_c1_req", bus_if.req, 1); chk("t1_c1_stall", stallreq, 1);
    cyc(); bus_if.ack = 1; bus_if.rdata = 32'h2401_0001;
    #1 chk("t1_c2_req", bus_if.req, 1); chk("t1_c2_stall", stallreq, 1);
    cyc(); bus_if.ack = 0;
    #1 chk("t1_c3_req", bus_if.req, 0); chk("t1_c3_stall", stallreq, 0);
    chk("t1_if_data", if_data, 32'h2401_0001); chk("t1_err", bus_if.err, 0);
    cyc(); if_ce = 0;
    cyc();

    // T2: simultaneous IF fetch and DM store, DM first
    cyc(); if_ce = 1; if_addr = 32'h104;
    dm_ce = 1; dm_we = 1; dm_sel = 4'b0011; dm_addr = 32'h8000_0010; dm_wdata = 32'h0000_BEEF;
    push(32'h8000_0010, 1, 4'b0011, 32'h0000_BEEF); push(32'h104, 0, 4'hF, 0);
    #1 chk("t2_c0_stall", stallreq, 1);
    cyc(); bus_if.ack = 1;
    #1 chk("t2_c1_req", bus_if.req, 1); chk("t2_c1_we", bus_if.we, 1);
    chk("t2_c1_sel", bus_if.sel, 4'b0011);
    cyc(); bus_if.ack = 0;
    #1 chk("t2_c2_req", bus_if.req, 0); chk("t2_c2_stall", stallreq, 1);
    cyc(); bus_if.ack = 1; bus_if.rdata = 32'h3C01_1234;
    #1 chk("t2_c3_req", bus_if.req, 1); chk("t2_c3_addr", bus_if.addr, 32'h104);
    chk("t2_c3_we", bus_if.we, 0); chk("t2_c3_stall", stallreq, 1);
    cyc(); bus_if.ack = 0;
    #1 chk("t2_c4_stall", stallreq, 0); chk("t2_if_data", if_data, 32'h3C01_1234);
    chk("t2_dm_data", dm_data, 0);
    cyc(); if_ce = 0; dm_ce = 0; dm_we = 0;
    cyc();

    // T3: DM load flushed while BUSY; same load then reissued
    cyc(); dm_ce = 1; dm_we = 0; dm_sel = 4'hF; dm_addr = 32'h8000_0020;
    push(32'h8000_0020, 0, 4'hF, 0); push(32'h8000_0020, 0, 4'hF, 0);
    cyc(); flush = 1;
    #1 chk("t3_c1_req", bus_if.req, 1);
    cyc(); flush = 0; bus_if.ack = 1; bus_if.rdata = 32'hDEAD_BEEF;
    #1 chk("t3_c2_req", bus_if.req, 1);
    cyc(); bus_if.ack = 0;
    #1 chk("t3_c3_req", bus_if.req, 0); chk("t3_dm_data_kept", dm_data, 0);
    chk("t3_not_served", stallreq, 1);
    cyc(); bus_if.ack = 1; bus_if.rdata = 32'h1122_3344;
    #1 chk("t3_c4_req", bus_if.req, 1);
    cyc(); bus_if.ack = 0;
    #1 chk("t3_c5_stall", stallreq, 0); chk("t3_dm_data", dm_data, 32'h1122_3344);
    cyc(); dm_ce = 0;
    cyc();

    // T6: back-to-back DM loads to the same address
    cyc(); dm_ce = 1; dm_addr = 32'h8000_0040;
    push(32'h8000_0040, 0, 4'hF, 0); push(32'h8000_0040, 0, 4'hF, 0);
    cyc(); bus_if.ack = 1; bus_if.rdata = 32'hA5A5_A5A5;
    #1 chk("t6_c1_req", bus_if.req, 1);
    cyc(); bus_if.ack = 0;
    #1 chk("t6_c2_stall", stallreq, 0); chk("t6_dm_data0", dm_data, 32'hA5A5_A5A5);
    cyc(); #1 chk("t6_c3_stall", stallreq, 1); chk("t6_c3_req", bus_if.req, 0);
    cyc(); bus_if.ack = 1; bus_if.rdata = 32'h5A5A_5A5A;
    #1 chk("t6_c4_req", bus_if.req, 1);
    cyc(); bus_if.ack = 0;
    #1 chk("t6_c5_stall", stallreq, 0); chk("t6_dm_data1", dm_data, 32'h5A5A_5A5A);
    cyc(); dm_ce = 0;
    cyc();

`ifdef MEM_ARB_TIMEOUT_EN
    // T5: DM load never acknowledged, aborted after four BUSY cycles
    cyc(); dm_ce = 1; dm_addr = 32'h8000_0080;
    for (int i = 1; i <= 4; i++) begin
      cyc(); #1 chk("t5_req_held", bus_if.req, 1); chk("t5_err_low", bus_if.err, 0);
    end
    cyc();
    #1 chk("t5_req_drop", bus_if.req, 0); chk("t5_err_pulse", bus_if.err, 1);
    chk("t5_dm_data", dm_data, 0); chk("t5_stall", stallreq, 0);
    cyc(); dm_ce = 0;
    #1 chk("t5_err_one_cycle", bus_if.err, 0);
    cyc();
`endif

    // T4: reset while BUSY_IF; effective only at the clock edge
    cyc(); if_ce = 1; if_addr = 32'h200;
    cyc(); #1 chk("t4_c1_req", bus_if.req, 1);
    rst = 1'b0; if_ce = 0;
    #2 chk("t4_req_before_edge", bus_if.req, 1);
    cyc(); #1 chk("t4_req", bus_if.req, 0); chk("t4_if_data", if_data, 0);
    chk("t4_dm_data", dm_data, 0); chk("t4_addr", bus_if.addr, 0);
    rst = 1'b1;
    cyc(); #1 chk("t4_idle_req", bus_if.req, 0); chk("t4_idle_stall", stallreq, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
